// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder, LSB first, one bit per clock.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADDER_OVF_EN.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             cy, s_bit, c_bit, accept, last;

  full_adder u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (cy),
    .s  (s_bit),
    .co (c_bit)
  );

  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST);
  // res_sh keeps the upper WIDTH-1 bits; the new bit enters at the MSB end
  assign res_nx = {s_bit, res_sh};
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      Sum    <= '0;
      Cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      Ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      cy   <= Cin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nx[WIDTH-1:1];
      cy     <= c_bit;
      cnt    <= cnt + 1'b1;
      if (last) begin
        Sum  <= res_nx;
        Cout <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
        // cy here is the carry into the MSB
        Ovf  <= cy ^ c_bit;
`endif
      end
    end
  end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 Port: A  input  WIDTH  first operand; sampled only when start is accepted.
REQ-006 Port: B  input  WIDTH  second operand; sampled only when start is accepted.
REQ-007 Port: Cin  input  1  carry-in; sampled only when start is accepted.
REQ-008 Port: busy  output  1  high while bits are being processed.
REQ-009 Port: done  output  1  one-cycle pulse marking a new valid result.
REQ-010 Port: Sum  output  WIDTH  registered result, A+B+Cin mod 2^WIDTH.
REQ-011 Port: Cout  output  1  registered carry-out of the full-width addition.

Function
REQ-012 The block SHALL compute one bit per cycle, LSB first, using the existing one-bit full_adder as its only arithmetic element.
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 Start SHALL be accepted only when busy is low, in either IDLE or DONE.
REQ-015 On acceptance: A and B SHALL be latched into shift registers, Cin into the carry flop, and the bit counter cleared; next state RUN.
REQ-016 In RUN, each cycle SHALL add the operand LSBs and the carry flop, shift the sum bit into the result register from the MSB end, store the new carry, and increment the counter.
REQ-017 After exactly WIDTH RUN cycles, the FSM SHALL go to DONE, and Sum and Cout SHALL load the final result on that same edge.
REQ-018 Latency: if start is accepted at edge N, done SHALL be high for exactly the cycle following edge N+WIDTH.
REQ-019 busy SHALL be high exactly in RUN, for WIDTH cycles.
REQ-020 DONE SHALL last one cycle. Next state is RUN if start is high, else IDLE.
REQ-021 Start asserted while busy SHALL be ignored, with no effect on the operation in progress or its result.
REQ-022 Sum and Cout SHALL change only on the edge that enters DONE, and SHALL hold until the next completion.
REQ-023 Operand changes on A, B or Cin after acceptance SHALL NOT affect the result.

Reset
REQ-024 While rst is high, the FSM SHALL be in IDLE, and busy, done, Sum and Cout SHALL be 0, independent of clk.
REQ-025 Reset during RUN SHALL abort the operation: no done pulse, and Sum and Cout are cleared.
REQ-026 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN: when defined, the block SHALL add output port Ovf (1 bit) giving signed overflow, i.e. the carry into the MSB XOR Cout.
REQ-028 Ovf SHALL be captured and reset with the same timing as Cout.
REQ-029 Without SERIAL_ADDER_OVF_EN, the Ovf port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-030 WIDTH=8, A=8'hFF, B=8'h01, Cin=0, start at edge 0 -> busy high for 8 cycles; done pulses after edge 8; Sum=8'h00, Cout=1.
REQ-031 A=8'hA5, B=8'h5A, Cin=1 -> Sum=8'h00, Cout=1. Then A=8'h12, B=8'h34, Cin=0 -> Sum=8'h46, Cout=0.
REQ-032 Start pulsed at cycle 3 of a running addition with different operands -> ignored; the result matches the first operands only.
REQ-033 start held high through the DONE cycle -> second addition begins without an IDLE cycle; the done pulses are exactly 9 cycles apart.
REQ-034 rst asserted mid-RUN at cycle 4 -> busy, done, Sum and Cout are 0 immediately; no done pulse follows; the next start completes correctly.
REQ-035 With SERIAL_ADDER_OVF_EN: A=8'h7F, B=8'h01 -> Sum=8'h80, Cout=0, Ovf=1. A=8'hFF, B=8'h01 -> Ovf=0.
